// File: rtl/rm_release_scheduler_if.sv
// Signal bundle between the release scheduler and its neighbours: allocation and
// completion events in, drain selection and free requests out.
interface rm_release_scheduler_if #(
  parameter int unsigned ID_WIDTH = 32,
  parameter int unsigned NUM_UIDS = 16
);
  localparam int unsigned UID_W = $clog2(NUM_UIDS);

  logic                alloc_valid;
  logic [UID_W-1:0]    alloc_uid;
  logic [ID_WIDTH-1:0] alloc_orig_id;
  logic                done_valid;
  logic [UID_W-1:0]    done_uid;
  logic                sel_valid;
  logic [UID_W-1:0]    sel_uid;
  logic                beat_fire;
  logic                beat_last;
  logic                free_req;
  logic [UID_W-1:0]    free_uid;
  logic [UID_W:0]      outstanding;
  logic                err_pulse;

  modport master (
    output alloc_valid, alloc_uid, alloc_orig_id, done_valid, done_uid, beat_fire, beat_last,
    input  sel_valid, sel_uid, free_req, free_uid, outstanding, err_pulse
  );

  modport slave (
    input  alloc_valid, alloc_uid, alloc_orig_id, done_valid, done_uid, beat_fire, beat_last,
    output sel_valid, sel_uid, free_req, free_uid, outstanding, err_pulse
  );
endinterface

// File: rtl/rm_release_scheduler.sv
// Picks which completed UID burst drains from response memory next, keeping per-original-ID
// order via a linked list per ID and round-robin arbitration among list heads.
module rm_release_scheduler #(
  parameter int unsigned ID_WIDTH = 32,
  parameter int unsigned NUM_UIDS = 16
) (
  input logic                   clk,
  input logic                   rst,
  rm_release_scheduler_if.slave bus
);
  localparam int unsigned UID_W = $clog2(NUM_UIDS);
  typedef logic [UID_W-1:0] uid_t;
  typedef enum logic [1:0] {StIdle, StDrain, StFree} state_e;

  state_e              state_q, state_d;
  logic [NUM_UIDS-1:0] valid_q, valid_d, complete_q, complete_d, head_q, head_d;
  logic [NUM_UIDS-1:0] tail_q, tail_d, has_next_q, has_next_d;
  logic [ID_WIDTH-1:0] orig_q [NUM_UIDS];
  logic [ID_WIDTH-1:0] orig_d [NUM_UIDS];
  uid_t                next_q [NUM_UIDS];
  uid_t                next_d [NUM_UIDS];
  uid_t                rr_ptr_q, rr_ptr_d, sel_uid_q, sel_uid_d, free_uid_q, free_uid_d;
  logic                sel_valid_q, sel_valid_d, free_req_q, free_req_d, err_q, err_d;
  logic [UID_W:0]      outstanding_q, outstanding_d;

  logic                free_now, alloc_ok, done_ok, hit, pick_found, beat_err;
  uid_t                hit_idx, pick_idx;
  logic [NUM_UIDS-1:0] eligible;

  assign free_now = (state_q == StFree);
  assign eligible = valid_q & complete_q & head_q;
  assign alloc_ok = bus.alloc_valid && !valid_q[bus.alloc_uid];
  assign done_ok  = bus.done_valid && valid_q[bus.done_uid] &&
                    !(bus.alloc_valid && (bus.alloc_uid == bus.done_uid));

  // Tail search; the entry being freed this cycle must not gain a successor.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM_UIDS; i++) begin
      if (!hit && valid_q[i] && tail_q[i] && (orig_q[i] == bus.alloc_orig_id) &&
          !(free_now && (sel_uid_q == uid_t'(i)))) begin
        hit     = 1'b1;
        hit_idx = uid_t'(i);
      end
    end
  end

  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 0; k < NUM_UIDS; k++) begin
      idx = (32'(rr_ptr_q) + k) % NUM_UIDS;
      if (!pick_found && eligible[idx]) begin
        pick_found = 1'b1;
        pick_idx   = uid_t'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_valid_d = sel_valid_q;
    sel_uid_d   = sel_uid_q;
    rr_ptr_d    = rr_ptr_q;
    free_req_d  = 1'b0;
    free_uid_d  = free_uid_q;
    beat_err    = 1'b0;
    unique case (state_q)
      StIdle: begin
        beat_err = bus.beat_fire;
        if (pick_found) begin
          sel_valid_d = 1'b1;
          sel_uid_d   = pick_idx;
          rr_ptr_d    = (pick_idx == uid_t'(NUM_UIDS - 1)) ? '0 : pick_idx + 1'b1;
          state_d     = StDrain;
        end
      end
      StDrain: begin
        if (bus.beat_fire && bus.beat_last) begin
          sel_valid_d = 1'b0;
          free_req_d  = 1'b1;
          free_uid_d  = sel_uid_q;
          state_d     = StFree;
        end
      end
      StFree: begin
        beat_err = bus.beat_fire;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Entry updates apply in order: done, alloc, then the free clear and successor promotion.
  always_comb begin
    valid_d    = valid_q;
    complete_d = complete_q;
    head_d     = head_q;
    tail_d     = tail_q;
    has_next_d = has_next_q;
    orig_d     = orig_q;
    next_d     = next_q;
    if (done_ok) complete_d[bus.done_uid] = 1'b1;
    if (alloc_ok) begin
      valid_d[bus.alloc_uid]    = 1'b1;
      complete_d[bus.alloc_uid] = 1'b0;
      head_d[bus.alloc_uid]     = !hit;
      tail_d[bus.alloc_uid]     = 1'b1;
      has_next_d[bus.alloc_uid] = 1'b0;
      orig_d[bus.alloc_uid]     = bus.alloc_orig_id;
      next_d[bus.alloc_uid]     = '0;
      if (hit) begin
        next_d[hit_idx]     = bus.alloc_uid;
        has_next_d[hit_idx] = 1'b1;
        tail_d[hit_idx]     = 1'b0;
      end
    end
    if (free_now) begin
      valid_d[sel_uid_q]    = 1'b0;
      complete_d[sel_uid_q] = 1'b0;
      head_d[sel_uid_q]     = 1'b0;
      tail_d[sel_uid_q]     = 1'b0;
      has_next_d[sel_uid_q] = 1'b0;
      orig_d[sel_uid_q]     = '0;
      next_d[sel_uid_q]     = '0;
      if (has_next_q[sel_uid_q]) head_d[next_q[sel_uid_q]] = 1'b1;
    end
  end

  always_comb begin
    err_d = (bus.alloc_valid && valid_q[bus.alloc_uid]) || beat_err ||
            (bus.done_valid && (!valid_q[bus.done_uid] ||
                                (bus.alloc_valid && (bus.alloc_uid == bus.done_uid))));
    unique case ({alloc_ok, free_now})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      valid_q       <= '0;
      complete_q    <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      has_next_q    <= '0;
      for (int i = 0; i < NUM_UIDS; i++) begin
        orig_q[i] <= '0;
        next_q[i] <= '0;
      end
      rr_ptr_q      <= '0;
      sel_valid_q   <= 1'b0;
      sel_uid_q     <= '0;
      free_req_q    <= 1'b0;
      free_uid_q    <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      complete_q    <= complete_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      has_next_q    <= has_next_d;
      orig_q        <= orig_d;
      next_q        <= next_d;
      rr_ptr_q      <= rr_ptr_d;
      sel_valid_q   <= sel_valid_d;
      sel_uid_q     <= sel_uid_d;
      free_req_q    <= free_req_d;
      free_uid_q    <= free_uid_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign bus.sel_valid   = sel_valid_q;
  assign bus.sel_uid     = sel_uid_q;
  assign bus.free_req    = free_req_q;
  assign bus.free_uid    = free_uid_q;
  assign bus.outstanding = outstanding_q;
  assign bus.err_pulse   = err_q;
endmodule

// File: tb/tb_rm_release_scheduler.sv
// Scoreboard bench: a transaction-level model (per-ID allocation order list) predicts
// selections, frees, error pulses and occupancy; a monitor compares them as the DUT shows them.
module tb_rm_release_scheduler;
  localparam int unsigned ID_WIDTH = 32;
  localparam int unsigned NUM_UIDS = 16;
  localparam int unsigned UID_W    = 4;
  localparam int          N        = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  rm_release_scheduler_if #(.ID_WIDTH(ID_WIDTH), .NUM_UIDS(NUM_UIDS)) bus ();
  rm_release_scheduler #(.ID_WIDTH(ID_WIDTH), .NUM_UIDS(NUM_UIDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef enum int {MIdle, MDrain, MFree} mphase_e;
  typedef struct {
    bit err;
    int out;
  } chk_t;

  mphase_e     mstate;
  int          msel, mrr;
  bit          mvalid [N];
  bit          mcomplete [N];
  bit [31:0]   morig [N];
  int          order_q[$];
  int          exp_sel[$], exp_free[$], free_log[$], want[$];
  chk_t        chk_q[$];
  chk_t        mon_c;
  int          checks = 0;
  int          errors = 0;
  int          cur_sel;
  bit          prev_sel;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(string what);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", what, $time);
  endtask

  function automatic bit is_head(int u);
    foreach (order_q[i]) if (morig[order_q[i]] == morig[u]) return order_q[i] == u;
    return 1'b0;
  endfunction

  function automatic int count_valid();
    int n = 0;
    for (int i = 0; i < N; i++) n += int'(mvalid[i]);
    return n;
  endfunction

  task automatic clear_inputs();
    bus.alloc_valid = 1'b0; bus.alloc_uid = '0; bus.alloc_orig_id = '0;
    bus.done_valid  = 1'b0; bus.done_uid  = '0;
    bus.beat_fire   = 1'b0; bus.beat_last = 1'b0;
  endtask

  task automatic model_reset();
    mstate = MIdle; msel = 0; mrr = 0;
    for (int i = 0; i < N; i++) begin mvalid[i] = 0; mcomplete[i] = 0; morig[i] = 0; end
    order_q.delete(); exp_sel.delete(); exp_free.delete(); chk_q.delete();
  endtask

  // Applies one clock of the reference model to the inputs currently driven.
  task automatic step();
    bit err, freeing, aok, dok;
    int a, d, fu, pick, sel_push, free_push;
    chk_t c;
    a = int'(bus.alloc_uid); d = int'(bus.done_uid);
    freeing = (mstate == MFree); fu = msel;
    sel_push = -1; free_push = -1;
    aok = bus.alloc_valid && !mvalid[a];
    dok = bus.done_valid && mvalid[d] && !(bus.alloc_valid && a == d);
    err = (bus.alloc_valid && mvalid[a]) || (bus.done_valid && !dok) ||
          (bus.beat_fire && mstate != MDrain);
    case (mstate)
      MIdle: begin
        pick = -1;
        for (int k = 0; k < N; k++) begin
          int u = (mrr + k) % N;
          if (pick < 0 && mvalid[u] && mcomplete[u] && is_head(u)) pick = u;
        end
        if (pick >= 0) begin
          msel = pick; mrr = (pick + 1) % N; sel_push = pick; mstate = MDrain;
        end
      end
      MDrain: if (bus.beat_fire && bus.beat_last) begin free_push = msel; mstate = MFree; end
      default: mstate = MIdle;
    endcase
    if (dok) mcomplete[d] = 1;
    if (freeing) begin
      foreach (order_q[i]) if (order_q[i] == fu) begin order_q.delete(i); break; end
      mvalid[fu] = 0; mcomplete[fu] = 0;
    end
    if (aok) begin
      order_q.push_back(a); mvalid[a] = 1; mcomplete[a] = 0; morig[a] = bus.alloc_orig_id;
    end
    @(posedge clk);
    if (sel_push >= 0) exp_sel.push_back(sel_push);
    if (free_push >= 0) exp_free.push_back(free_push);
    c.err = err; c.out = count_valid(); chk_q.push_back(c);
    #1;
    clear_inputs();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic alloc(int u, int o);
    bus.alloc_valid = 1'b1; bus.alloc_uid = UID_W'(u); bus.alloc_orig_id = 32'(o);
    step();
  endtask

  task automatic done(int u);
    bus.done_valid = 1'b1; bus.done_uid = UID_W'(u);
    step();
  endtask

  task automatic wait_drain();
    int n = 0;
    while (mstate != MDrain && n < 40) begin step(); n++; end
    if (mstate != MDrain) flag("wait_drain: no selection within 40 cycles");
  endtask

  task automatic beats(int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 1) step();
      bus.beat_fire = 1'b1; bus.beat_last = (i == n - 1);
      step();
    end
  endtask

  task automatic check_log(string name);
    check({name, "_count"}, free_log.size(), want.size());
    for (int i = 0; i < want.size() && i < free_log.size(); i++) check(name, free_log[i], want[i]);
    free_log.delete();
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    free_log.delete();
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  initial begin
    prev_sel = 0; cur_sel = 0;
    forever begin
      @(negedge clk);
      if (rst) prev_sel = 0;
      else begin
        if (chk_q.size() > 0) begin
          mon_c = chk_q.pop_front();
          check("err_pulse", int'(bus.err_pulse), int'(mon_c.err));
          check("outstanding", int'(bus.outstanding), mon_c.out);
        end
        if (bus.sel_valid && !prev_sel) begin
          if (exp_sel.size() > 0) begin
            cur_sel = exp_sel.pop_front();
            check("sel_uid", int'(bus.sel_uid), cur_sel);
          end else flag($sformatf("unexpected sel_valid rise, sel_uid=%0d", bus.sel_uid));
        end else if (bus.sel_valid) check("sel_uid_hold", int'(bus.sel_uid), cur_sel);
        if (bus.free_req) begin
          if (exp_free.size() > 0) check("free_uid", int'(bus.free_uid), exp_free.pop_front());
          else flag($sformatf("unexpected free_req, free_uid=%0d", bus.free_uid));
          free_log.push_back(int'(bus.free_uid));
        end
        prev_sel = bus.sel_valid;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int guard;
    clear_inputs();
    model_reset();
    #1 rst = 1'b1;
    #2;
    check("reset_sel_valid", int'(bus.sel_valid), 0);
    check("reset_sel_uid", int'(bus.sel_uid), 0);
    check("reset_free_req", int'(bus.free_req), 0);
    check("reset_free_uid", int'(bus.free_uid), 0);
    check("reset_outstanding", int'(bus.outstanding), 0);
    check("reset_err_pulse", int'(bus.err_pulse), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Single burst
    alloc(3, 'h5); done(3); wait_drain(); beats(4); idle(2);
    want = {3}; check_log("single_order");

    // Same-ID ordering: later UID completes first but must wait
    alloc(1, 'hA); alloc(2, 'hA); done(2); idle(10); done(1);
    wait_drain(); beats(2); wait_drain(); beats(3); idle(2);
    want = {1, 2}; check_log("same_id_order");

    // Round-robin from rr_ptr=0 (blocker uid15 wraps the pointer)
    do_reset();
    alloc(15, 'h99); done(15); wait_drain();
    for (int u = 0; u < 4; u++) alloc(u, 'h10 + u);
    for (int u = 0; u < 4; u++) done(u);
    beats(1);
    for (int u = 0; u < 4; u++) begin wait_drain(); beats(1); end
    idle(2);
    want = {15, 0, 1, 2, 3}; check_log("rr_order");
    // Blocker uid1 leaves rr_ptr at 2; uid3 must beat uid0
    alloc(1, 'h20); done(1); wait_drain();
    alloc(0, 'h21); alloc(3, 'h22); done(0); done(3); beats(1);
    wait_drain(); beats(1); wait_drain(); beats(1); idle(2);
    want = {1, 3, 0}; check_log("rr_wrap_order");

    // Alloc with the same ID while the tail is being freed
    alloc(5, 'h7); done(5); wait_drain(); beats(2);
    alloc(6, 'h7); done(6); wait_drain(); beats(1); idle(2);
    want = {5, 6}; check_log("free_collision_order");

    // Protocol errors
    done(9); idle(1);
    bus.beat_fire = 1'b1; bus.beat_last = 1'b1; step(); idle(1);
    alloc(7, 'h1); alloc(7, 'h2); idle(1);
    done(7); wait_drain(); beats(1); idle(2);

    // Async reset mid-drain
    alloc(4, 'h44); done(4); wait_drain();
    bus.beat_fire = 1'b1; step(); step();
    #2 rst = 1'b1;
    #1;
    check("midreset_sel_valid", int'(bus.sel_valid), 0);
    check("midreset_outstanding", int'(bus.outstanding), 0);
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    idle(6);
    free_log.delete();

    // Randomized traffic
    for (int it = 0; it < 1500; it++) begin
      int u;
      if ($urandom_range(0, 2) == 0) begin
        u = $urandom_range(0, N - 1);
        if (!mvalid[u] || $urandom_range(0, 15) == 0) begin
          bus.alloc_valid = 1'b1; bus.alloc_uid = UID_W'(u);
          bus.alloc_orig_id = 32'($urandom_range(0, 3));
        end
      end
      if ($urandom_range(0, 2) == 0) begin
        u = $urandom_range(0, N - 1);
        if ((mvalid[u] && !mcomplete[u]) || $urandom_range(0, 15) == 0) begin
          bus.done_valid = 1'b1; bus.done_uid = UID_W'(u);
        end
      end
      if (mstate == MDrain && $urandom_range(0, 1) == 1) begin
        bus.beat_fire = 1'b1; bus.beat_last = ($urandom_range(0, 3) == 0);
      end else if (mstate != MDrain && $urandom_range(0, 63) == 0) bus.beat_fire = 1'b1;
      step();
    end

    // Complete and drain everything still outstanding
    guard = 0;
    while ((count_valid() > 0 || mstate != MIdle) && guard < 4000) begin
      for (int u = 0; u < N; u++) begin
        if (mvalid[u] && !mcomplete[u] && !bus.done_valid) begin
          bus.done_valid = 1'b1; bus.done_uid = UID_W'(u);
        end
      end
      if (mstate == MDrain) begin
        bus.beat_fire = 1'b1; bus.beat_last = ($urandom_range(0, 2) == 0);
      end
      step();
      guard++;
    end
    if (guard >= 4000) flag("final drain did not empty within 4000 cycles");
    idle(3);
    check("pending_sel_expectations", exp_sel.size(), 0);
    check("pending_free_expectations", exp_free.size(), 0);
    check("final_outstanding", int'(bus.outstanding), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
